// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                     |
// | Brief    : Shared types and constants for the instruction-fetch stage.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        IMM    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Bit of the first word that marks a two-word (long) instruction
    localparam int         LONG_BIT = 15;
    localparam logic [4:0] HALT_OPC = 5'b00001;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : fetch_pc_unit                                                 |
// | Brief    : Program counter register with hold / +1 / redirect / reset.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_pc_unit #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = 20'h00020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // Increment wraps naturally at 2^ADDR_W
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirect_addr;
        end else if (i_advance) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                               |
// | Brief    : Fetch-stage sequencer assembling 16/32-bit instructions.      |
// |            Optional halt support enabled by macro FETCH_HALT_EN.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = 20'h00020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic [15:0]       imem_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    fetch_state_t      r_state, w_state_nxt;
    logic [15:0]       r_w0, w_w0_nxt;
    logic [ADDR_W-1:0] r_w0_pc, w_w0_pc_nxt;
    logic [31:0]       r_instr, w_instr_nxt;
    logic [ADDR_W-1:0] r_instr_pc, w_instr_pc_nxt;
    logic              r_instr_valid, w_instr_valid_nxt;
    logic              w_advance;
    logic [ADDR_W-1:0] w_pc;

    fetch_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst             (rst),
        .i_redirect      (redirect_valid),
        .i_redirect_addr (redirect_addr),
        .i_advance       (w_advance),
        .o_pc            (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_w0          <= '0;
            r_w0_pc       <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_w0          <= w_w0_nxt;
            r_w0_pc       <= w_w0_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_w0_nxt          = r_w0;
        w_w0_pc_nxt       = r_w0_pc;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_advance         = 1'b0;

        if (redirect_valid) begin
            w_state_nxt       = FETCH;
            w_instr_valid_nxt = 1'b0;
        end else if (!stall) begin
            case (r_state)
                FETCH: begin
                    w_advance = 1'b1;
                    w_w0_nxt  = imem_data;
                    if (imem_data[LONG_BIT]) begin
                        w_w0_pc_nxt       = w_pc;
                        w_instr_valid_nxt = 1'b0;
                        w_state_nxt       = IMM;
                    end else begin
                        w_instr_nxt       = {imem_data, 16'h0000};
                        w_instr_pc_nxt    = w_pc;
                        w_instr_valid_nxt = 1'b1;
`ifdef FETCH_HALT_EN
                        if (imem_data[15:11] == HALT_OPC) begin
                            w_state_nxt = HALTED;
                        end
`endif
                    end
                end
                IMM: begin
                    w_advance         = 1'b1;
                    w_instr_nxt       = {r_w0, imem_data};
                    w_instr_pc_nxt    = r_w0_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = FETCH;
                end
                HALTED: begin
                    w_instr_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    assign imem_addr   = w_pc;
    assign imem_rd     = !stall && (r_state != HALTED);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

`ifdef FETCH_HALT_EN
    assign halted = (r_state == HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_sequencer                                            |
// | Brief    : Directed self-checking bench for fetch_sequencer.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [19:0] redirect_addr;
    logic [15:0] imem_data;
    logic [19:0] imem_addr;
    logic        imem_rd;
    logic [31:0] instr;
    logic        instr_valid;
    logic [19:0] instr_pc;
    logic        halted;
    int          scenario;
    int          n_cmp;
    int          n_bad;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    // Memory image per scenario; unlisted addresses hold a short word = low address bits
    function automatic logic [15:0] memf(input logic [19:0] a, input int s);
        logic [15:0] d;
        d = {1'b0, a[14:0]};
        if (s == 0 && a == 20'h00020) d = 16'h1234;
        if (s == 1 && a == 20'h00020) d = 16'h8123;
        if (s == 1 && a == 20'h00021) d = 16'h00FF;
        if (s == 1 && a == 20'hFFFFF) d = 16'hC0DE;
        if (s == 1 && a == 20'h00000) d = 16'h4455;
        if (s == 2 && a == 20'h00020) d = 16'h0800;
        return d;
    endfunction

    assign imem_data = memf(imem_addr, scenario);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        scenario       = s;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %h want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 20'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", instr_pc); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted got %h want 0", halted); end
        n_cmp++; if (imem_addr !== 20'h00020) begin n_bad++; $display("FAIL rst_addr got %h want 00020", imem_addr); end
        n_cmp++; if (imem_rd !== 1'b1) begin n_bad++; $display("FAIL rst_rd got %h want 1", imem_rd); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h12340000, 20'h00020}) begin
            n_bad++; $display("FAIL short0 got v=%h i=%h pc=%h want 1 12340000 00020", instr_valid, instr, instr_pc); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h00210000, 20'h00021}) begin
            n_bad++; $display("FAIL short1 got v=%h i=%h pc=%h want 1 00210000 00021", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_long();
        do_reset(1);
        step();
        n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 20'h00021) begin
            n_bad++; $display("FAIL long_mid got v=%h a=%h want 0 00021", instr_valid, imem_addr); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b1, 32'h812300FF, 20'h00020, 20'h00022}) begin
            n_bad++; $display("FAIL long got v=%h i=%h pc=%h a=%h want 1 812300ff 00020 00022",
                              instr_valid, instr, instr_pc, imem_addr); end
    endtask

    task automatic test_stall();
        do_reset(1);
        step();
        stall = 1'b1;
        #1;
        n_cmp++; if (imem_rd !== 1'b0) begin n_bad++; $display("FAIL stall_rd got %h want 0", imem_rd); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if ({instr_valid, imem_addr} !== {1'b0, 20'h00021}) begin
                n_bad++; $display("FAIL stall_imm%0d got v=%h a=%h want 0 00021", k, instr_valid, imem_addr); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h812300FF, 20'h00020}) begin
            n_bad++; $display("FAIL stall_rel got v=%h i=%h pc=%h want 1 812300ff 00020", instr_valid, instr, instr_pc); end
        stall = 1'b1;
        step();
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b1, 32'h812300FF, 20'h00020, 20'h00022}) begin
            n_bad++; $display("FAIL stall_hold got v=%h i=%h pc=%h a=%h want 1 812300ff 00020 00022",
                              instr_valid, instr, instr_pc, imem_addr); end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset(1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 20'h00100;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if ({instr_valid, imem_addr} !== {1'b0, 20'h00100}) begin
            n_bad++; $display("FAIL redir got v=%h a=%h want 0 00100", instr_valid, imem_addr); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h01000000, 20'h00100}) begin
            n_bad++; $display("FAIL redir_next got v=%h i=%h pc=%h want 1 01000000 00100", instr_valid, instr, instr_pc); end
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 20'h00040;
        step();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        n_cmp++; if ({instr_valid, imem_addr} !== {1'b0, 20'h00040}) begin
            n_bad++; $display("FAIL redir_stall got v=%h a=%h want 0 00040", instr_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_addr  = 20'hFFFFF;
        step();
        redirect_valid = 1'b0;
        step();
        n_cmp++; if ({instr_valid, imem_addr} !== {1'b0, 20'h00000}) begin
            n_bad++; $display("FAIL wrap_mid got v=%h a=%h want 0 00000", instr_valid, imem_addr); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b1, 32'hC0DE4455, 20'hFFFFF, 20'h00001}) begin
            n_bad++; $display("FAIL wrap got v=%h i=%h pc=%h a=%h want 1 c0de4455 fffff 00001",
                              instr_valid, instr, instr_pc, imem_addr); end
    endtask

    task automatic test_halt();
        do_reset(2);
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b1, 32'h08000000, 20'h00020, 20'h00021}) begin
            n_bad++; $display("FAIL halt_emit got v=%h i=%h pc=%h a=%h want 1 08000000 00020 00021",
                              instr_valid, instr, instr_pc, imem_addr); end
`ifdef FETCH_HALT_EN
        n_cmp++; if ({halted, imem_rd} !== 2'b10) begin
            n_bad++; $display("FAIL halt_state got h=%h rd=%h want 1 0", halted, imem_rd); end
        step();
        step();
        n_cmp++; if ({halted, imem_rd, instr_valid, imem_addr} !== {3'b100, 20'h00021}) begin
            n_bad++; $display("FAIL halt_hold got h=%h rd=%h v=%h a=%h want 1 0 0 00021",
                              halted, imem_rd, instr_valid, imem_addr); end
        redirect_valid = 1'b1;
        redirect_addr  = 20'h00040;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if ({halted, imem_rd, imem_addr} !== {2'b01, 20'h00040}) begin
            n_bad++; $display("FAIL halt_exit got h=%h rd=%h a=%h want 0 1 00040", halted, imem_rd, imem_addr); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h00400000, 20'h00040}) begin
            n_bad++; $display("FAIL halt_resume got v=%h i=%h pc=%h want 1 00400000 00040", instr_valid, instr, instr_pc); end
`else
        n_cmp++; if ({halted, imem_rd} !== 2'b01) begin
            n_bad++; $display("FAIL nohalt_state got h=%h rd=%h want 0 1", halted, imem_rd); end
        step();
        n_cmp++; if ({instr_valid, instr, instr_pc, halted} !== {1'b1, 32'h00210000, 20'h00021, 1'b0}) begin
            n_bad++; $display("FAIL nohalt_next got v=%h i=%h pc=%h h=%h want 1 00210000 00021 0",
                              instr_valid, instr, instr_pc, halted); end
`endif
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        scenario       = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        test_reset();
        test_long();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the instruction-fetch stage: owns the program counter, drives the instruction memory address and read enable, and assembles one- or two-word (16/32-bit) instructions for decode. Sits between the instruction memory and the IF/ID pipeline register. Handles decode-side stall and execute-side redirect (branch/jump/flush).

## Interface
- `ADDR_W`, 20: instruction memory address width, in 16-bit words.
- `RESET_PC`, 20'h00020: PC loaded on reset.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: decode cannot accept; freeze the sequencer.
- `redirect_valid`, in, 1: load a new PC and flush the partial instruction.
- `redirect_addr`, in, ADDR_W: target PC for a redirect.
- `imem_data`, in, 16: instruction memory read data. Combinational, valid in the same cycle as `imem_addr`.
- `imem_addr`, out, ADDR_W: equals the current `pc` register.
- `imem_rd`, out, 1: memory read enable.
- `instr`, out, 32: `{first_word, immediate}`. Short instructions give `{first_word, 16'h0000}`.
- `instr_valid`, out, 1: `instr` is valid this cycle.
- `instr_pc`, out, ADDR_W: address of the instruction's first word.
- `halted`, out, 1: sequencer is halted (see Configuration).

## Operation
- States: `FETCH`, `IMM`, `HALTED`.
- **Reset:** `pc`=`RESET_PC`, state=`FETCH`. `instr`, `instr_pc`, `instr_valid` and `halted` are all 0.
- `imem_rd` = !`stall` && state != `HALTED`.
- **Priority per cycle:** `rst` > `redirect_valid` > `stall` > normal.
- **Redirect:**
  - `pc` <= `redirect_addr`, state <= `FETCH`, `instr_valid` <= 0.
  - Any held first word is discarded.
  - Redirect also exits `HALTED`.
  - A redirect asserted together with `stall` is still taken.
- **Stall (no redirect):** every register holds. `instr`, `instr_valid` and `instr_pc` stay stable so decode sees the same instruction.
- **`FETCH`, normal:**
  - Sample `imem_data` into `w0`; `pc` <= `pc`+1.
  - If `imem_data[LONG_BIT]`=1: hold `w0` and its PC, `instr_valid` <= 0, state <= `IMM`.
  - Otherwise: `instr` <= `{imem_data,16'h0}`, `instr_pc` <= `pc`, `instr_valid` <= 1.
- **`IMM`, normal:**
  - `instr` <= `{w0, imem_data}`, `instr_pc` <= PC of `w0`, `instr_valid` <= 1.
  - `pc` <= `pc`+1, state <= `FETCH`.
- **PC arithmetic:** modulo 2^`ADDR_W`. `pc` = all-ones increments to 0. A long instruction whose first word is at the top address takes its immediate from address 0.

## Timing
- Throughput: one short instruction per cycle; one long instruction per two cycles.
- Latency: a word addressed in cycle N appears on `instr` with `instr_valid`=1 after the edge ending cycle N (short) or cycle N+1 (long).
- The first `instr_valid` after reset release is one cycle later.
- Redirect in cycle N: `imem_addr`=`redirect_addr` in cycle N+1 and `instr_valid`=0 in cycle N+1.
- Stall in cycle N: no change is visible in cycle N+1.
- All outputs except `imem_addr` and `imem_rd` are registered.

## Configuration
- Macro: `FETCH_HALT_EN`.
- **Defined:** a first word with `[15:11]`==`HALT_OPC`, in `FETCH`, is emitted as a valid short instruction. Then:
  - state <= `HALTED`, and `pc` holds at halt address + 1.
  - `halted`=1 from the next cycle.
  - `imem_rd`=0 and `instr_valid` <= 0.
  - Exit only via `rst` or `redirect_valid`.
- **Undefined:** `HALTED` is unreachable, `HALT_OPC` is an ordinary short instruction, and `halted` is tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (`FETCH`, `IMM`, `HALTED`);
  - `LONG_BIT` = 15;
  - `HALT_OPC` = 5'b00001.
- Sub-module `fetch_pc_unit` holds the `pc` register and the next-PC mux (hold / +1 / redirect / reset). The FSM stays in `fetch_sequencer`.

## Test plan
- Reset, then release: `imem_addr`=0x00020 and `instr_valid`=0 in the first cycle. Memory 0x20=0x1234 gives `instr`=0x12340000, `instr_pc`=0x20, `instr_valid`=1 next cycle.
- Long instruction: 0x20=0x8123, 0x21=0x00FF gives `instr`=0x812300FF and `instr_pc`=0x20 after two cycles, with no valid in between. `imem_addr` then = 0x22.
- `stall` for 3 cycles while in `IMM`: `pc` holds at 0x21 and outputs stay frozen. Release gives `instr`=0x812300FF.
- Redirect to 0x100 while in `IMM`: the partial instruction is dropped, `instr_valid`=0, `imem_addr`=0x100. Next `instr_pc`=0x100.
- Wrap: redirect to 0xFFFFF containing a long instruction, immediate at 0x00000: `instr` = `{mem[0xFFFFF], mem[0]}`, then `imem_addr`=0x00001.
- With `FETCH_HALT_EN`: 0x0800 at 0x20 is emitted valid, then `halted`=1, `imem_rd`=0 and `pc`=0x21 stays put. Redirect to 0x40 clears `halted`. Without the macro, fetch continues at 0x21.
